freq_gate_reader: RTL and testbench
===================================

# freq_gate_reader

Gated edge-count reader for the frequency meter: opens a gate of exactly `GATE_CYCLES` reference-clock cycles and counts rising edges of an asynchronous input during it. It then publishes the saturating count as one measurement record on a valid/ready interface. It is the timebase and readout end of the measurement path, and reports counts in the same 33-bit, saturate-at-32'hFFFFFFFF format the meter already uses.

## Interface
- `GATE_CYCLES`, 50_000_000: gate length in `clk` cycles (1 s at 50 MHz); must be ≥1.
- `CNT_W`, 33: result width.
- `SAT_MAX`, 32'hFFFFFFFF: saturation ceiling of the edge count.
- `SYNC_STAGES`, 2: synchronizer depth for `sig_in`; must be ≥2.
- `clk` in 1: reference clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `sig_in` in 1: measured signal, asynchronous to `clk`.
- `start` in 1: request one measurement; sampled only in IDLE.
- `continuous` in 1: when high at handshake, the next gate starts automatically.
- `busy` out 1: high in every state except IDLE.
- `result` out CNT_W: edge count of the last completed gate.
- `overflow` out 1: the count reached `SAT_MAX` during the gate.
- `result_valid` out 1: `result`/`overflow` valid; held until accepted.
- `result_ready` in 1: consumer accepts the record.

## Operation
- States and transitions:
  - IDLE → ARM when `start`=1.
  - ARM → GATE unconditionally. ARM clears the edge counter and the gate timer.
  - GATE → HOLD after `GATE_CYCLES` GATE cycles.
  - HOLD → ARM on handshake when `continuous`=1.
  - HOLD → IDLE on handshake when `continuous`=0.
- Handshake = `result_valid` & `result_ready` in the same cycle.
- Edge detect: `sig_in` passes through `SYNC_STAGES` flops, then one delay flop; edge = sync & ~delayed.
- Count rules:
  - The count increments on an edge only while in GATE and count < `SAT_MAX`.
  - At `SAT_MAX` the count holds and `overflow` latches for that gate.
  - Edges seen in IDLE, ARM or HOLD are discarded.
- On entry to HOLD, the count and overflow are copied to `result`/`overflow`. They stay stable through HOLD.
- `start` while `busy` is ignored; it is neither queued nor able to restart a gate.
- `result_ready` outside HOLD is ignored.
- Inputs faster than `clk`/2 alias; the block does not detect this.
- Reset (any state, including mid-gate):
  - All state returns to IDLE.
  - `busy`=0, `result_valid`=0, `result`=0, `overflow`=0, synchronizer flops cleared.
  - A partial gate is discarded and never reported.

## Timing
- `start` high at cycle t (IDLE): ARM at t+1, GATE from t+2 to t+1+`GATE_CYCLES`, `result_valid`=1 from t+2+`GATE_CYCLES`.
- `busy` rises at t+1 and falls the cycle after a non-continuous handshake.
- Handshake at cycle h:
  - `result_valid`=0 at h+1.
  - With `continuous`, ARM at h+1 and the next gate starts at h+2.
  - Dead time between continuous gates is at least 2 cycles (HOLD + ARM).
- Input latency: a `sig_in` rise reaches the counter `SYNC_STAGES`+1 cycles later. Edges within that window of a gate boundary may land in either gate; at most ±1 count error.
- `result_ready` tied high: HOLD lasts exactly 1 cycle.
- `result` is registered; the state register is the only path from `start` to other outputs.

## Structure
- Shared package `freq_meter_pkg` holds:
  - the state enum (IDLE, ARM, GATE, HOLD);
  - `CNT_W` default 33;
  - `SAT_MAX` default 32'hFFFFFFFF;
  - the default `GATE_CYCLES` value.
- One sub-module, `edge_sync`: the `SYNC_STAGES` synchronizer plus rising-edge pulse output, with async active-low clear.
- The gate timer is sized $clog2(`GATE_CYCLES`+1) and lives in the top level with the FSM and edge counter.

## Test plan
All scenarios use `GATE_CYCLES`=100 unless noted.
- Period test: `sig_in` period 10 `clk`, `start` pulse at t → `result`=10, `overflow`=0, `result_valid` rises at t+102, `busy` 1 from t+1.
- Static input: `sig_in` held 0, then held 1 → `result`=0 both times.
- Saturation: `SAT_MAX`=5, period 4 → `result`=5, `overflow`=1; the next gate with a static input gives `overflow`=0.
- Backpressure and continuous mode: `result_ready` low for 20 cycles → `result` stable, no new gate, `start` ignored. Then handshake with `continuous`=1 → ARM next cycle and a second valid record 102 cycles after the handshake.
- Reset mid-gate: `rst` low at gate cycle 50 → all outputs 0 immediately, IDLE. A fresh `start` then yields a correct full-gate count, not a partial one.
- Busy start: `start` pulses during GATE and HOLD → exactly one record produced; with `result_ready` tied high, HOLD lasts 1 cycle.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared types and defaults for the frequency meter measurement path.
// Counts are CNT_W bits wide and saturate at SAT_MAX.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StGate,
        StHold
    } fm_state_e;

    localparam int unsigned    CNT_W_DEF       = 33;
    localparam logic [32:0]    SAT_MAX_DEF     = 33'h0_FFFF_FFFF;
    localparam int unsigned    GATE_CYCLES_DEF = 50_000_000;
    localparam int unsigned    SYNC_STAGES_DEF = 2;

    // Wide enough to hold GATE_CYCLES itself, the value the timer lands on as the gate closes.
    function automatic int unsigned timer_width(input int unsigned gate_cycles);
        return $clog2(gate_cycles + 1);
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchronizer for an asynchronous input followed by a rising-edge detector.
// Produces a one-cycle pulse per synchronized rising edge; cleared by async active-low reset.
module edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("edge_sync: SYNC_STAGES must be >= 2");
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_o = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/freq_gate_reader.sv
// Gated edge-count reader: opens a GATE_CYCLES-long gate, counts synchronized rising edges of
// sig_in_i with saturation, and publishes the count as one record on a valid/ready interface.
module freq_gate_reader
    import freq_meter_pkg::*;
#(
    parameter int unsigned       GATE_CYCLES = GATE_CYCLES_DEF,
    parameter int unsigned       CNT_W       = CNT_W_DEF,
    parameter logic [CNT_W-1:0]  SAT_MAX     = CNT_W'(SAT_MAX_DEF),
    parameter int unsigned       SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             sig_in_i,
    input  logic             start_i,
    input  logic             continuous_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] result_o,
    output logic             overflow_o,
    output logic             result_valid_o,
    input  logic             result_ready_i
);

    localparam int unsigned     TW        = timer_width(GATE_CYCLES);
    localparam logic [TW-1:0]   GATE_LAST = TW'(GATE_CYCLES - 1);

    if (GATE_CYCLES < 1) begin : g_bad_gate
        $error("freq_gate_reader: GATE_CYCLES must be >= 1");
    end

    fm_state_e        state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] result_q, result_d;
    logic             res_ovf_q, res_ovf_d;
    logic             sig_edge;
    logic             gate_done;

    edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .sig_i  (sig_in_i),
        .edge_o (sig_edge)
    );

    assign gate_done = (state_q == StGate) && (timer_q == GATE_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StArm;
                end
            end
            StArm: begin
                state_d = StGate;
            end
            StGate: begin
                if (gate_done) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                // result_valid_o is high for the whole of HOLD, so ready alone completes the handshake.
                if (result_ready_i) begin
                    state_d = continuous_i ? StArm : StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        timer_d = timer_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (state_q == StArm) begin
            timer_d = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else if (state_q == StGate) begin
            timer_d = timer_q + TW'(1);
            if (sig_edge && (cnt_q < SAT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (cnt_d >= SAT_MAX) begin
                ovf_d = 1'b1;
            end
        end
    end

    // Capture uses the next-state count so an edge in the final gate cycle is not lost.
    always_comb begin
        result_d  = result_q;
        res_ovf_d = res_ovf_q;
        if (gate_done) begin
            result_d  = cnt_d;
            res_ovf_d = ovf_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            result_q  <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            result_q  <= result_d;
            res_ovf_q <= res_ovf_d;
        end
    end

    assign busy_o         = (state_q != StIdle);
    assign result_valid_o = (state_q == StHold);
    assign result_o       = result_q;
    assign overflow_o     = res_ovf_q;

endmodule

// File: tb/tb_freq_gate_reader.sv
// Self-checking bench: two readers (default and tiny saturation ceiling) share one stimulus,
// checked against fixed vectors, a history-based edge-count model and hand-written corner cases.
module tb_freq_gate_reader;

    localparam int            G     = 100;
    localparam int            SYNC  = 2;
    localparam int unsigned   CW    = 33;
    localparam logic [CW-1:0] SAT_A = 33'h0_FFFF_FFFF;
    localparam logic [CW-1:0] SAT_S = 33'd5;
    localparam int            MAXC  = 16384;

    logic          clk, rst_n, sig, start, cont, ready;
    logic          busy_a, ovf_a, valid_a, busy_s, ovf_s, valid_s;
    logic [CW-1:0] res_a, res_s;

    int          nvec, nfail, cyc, mode, period;
    int unsigned dens;
    logic        sig_hist [MAXC];

    typedef struct {
        int mode;
        int period;
        int exp_a;
        int ovf_a;
        int exp_s;
        int ovf_s;
    } vec_t;

    vec_t vecs [7];

    freq_gate_reader #(
        .GATE_CYCLES (G),
        .CNT_W       (CW),
        .SAT_MAX     (SAT_A),
        .SYNC_STAGES (SYNC)
    ) u_dut_a (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .sig_in_i       (sig),
        .start_i        (start),
        .continuous_i   (cont),
        .busy_o         (busy_a),
        .result_o       (res_a),
        .overflow_o     (ovf_a),
        .result_valid_o (valid_a),
        .result_ready_i (ready)
    );

    freq_gate_reader #(
        .GATE_CYCLES (G),
        .CNT_W       (CW),
        .SAT_MAX     (SAT_S),
        .SYNC_STAGES (SYNC)
    ) u_dut_s (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .sig_in_i       (sig),
        .start_i        (start),
        .continuous_i   (cont),
        .busy_o         (busy_s),
        .result_o       (res_s),
        .overflow_o     (ovf_s),
        .result_valid_o (valid_s),
        .result_ready_i (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge, and sig is logged per cycle.
    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        case (mode)
            0:       sig = 1'b0;
            1:       sig = 1'b1;
            2:       sig = ((cyc % period) < (period / 2)) ? 1'b1 : 1'b0;
            default: sig = ($urandom_range(0, 99) < dens) ? 1'b1 : 1'b0;
        endcase
        if (cyc < MAXC) sig_hist[cyc] = sig;
    endtask

    // Rises in the input log that fall inside the gate once the synchronizer latency is applied.
    function automatic logic [63:0] model_edges(input int t);
        logic [63:0] n;
        n = 0;
        for (int c = t + 2 - SYNC; c <= t + 1 + G - SYNC; c++) begin
            if (c > 0 && c < MAXC && sig_hist[c] && !sig_hist[c-1]) n++;
        end
        return n;
    endfunction

    task automatic do_start(output int t);
        tick();
        start = 1'b1;
        t = cyc;
        chk("busy_before_start", 64'(busy_a), 64'd0);
        tick();
        start = 1'b0;
        chk("busy_after_start", 64'(busy_a), 64'd1);
    endtask

    task automatic wait_valid(output int v);
        int budget;
        budget = G + 20;
        v = -1;
        while (budget > 0 && !valid_a) begin
            tick();
            budget--;
        end
        if (valid_a) v = cyc;
    endtask

    task automatic accept(input logic c, output int h);
        h = cyc;
        ready = 1'b1;
        cont = c;
        tick();
        ready = 1'b0;
        cont = 1'b0;
        chk("valid_after_hs", 64'(valid_a), 64'd0);
        chk("busy_after_hs", 64'(busy_a), 64'(c));
    endtask

    task automatic check_record(input string name, input int t, input int v);
        logic [63:0] n, ea, es;
        n  = model_edges(t);
        ea = (n > 64'(SAT_A)) ? 64'(SAT_A) : n;
        es = (n > 64'(SAT_S)) ? 64'(SAT_S) : n;
        chk({name, "_valid_cycle"}, 64'(v), 64'(t + 2 + G));
        chk({name, "_valid_s"}, 64'(valid_s), 64'd1);
        chk({name, "_result_a"}, 64'(res_a), ea);
        chk({name, "_ovf_a"}, 64'(ovf_a), (n >= 64'(SAT_A)) ? 64'd1 : 64'd0);
        chk({name, "_result_s"}, 64'(res_s), es);
        chk({name, "_ovf_s"}, 64'(ovf_s), (n >= 64'(SAT_S)) ? 64'd1 : 64'd0);
    endtask

    initial begin
        int t, v, h, nrec;
        logic ok;
        logic c;
        nvec = 0; nfail = 0; cyc = 0;
        mode = 0; period = 10; dens = 50;
        rst_n = 1'b0; sig = 1'b0; start = 1'b0; cont = 1'b0; ready = 1'b0;
        for (int i = 0; i < MAXC; i++) sig_hist[i] = 1'b0;

        vecs[0] = '{0, 10, 0, 0, 0, 0};
        vecs[1] = '{1, 10, 0, 0, 0, 0};
        vecs[2] = '{2, 10, 10, 0, 5, 1};
        vecs[3] = '{2, 4, 25, 0, 5, 1};
        vecs[4] = '{0, 10, 0, 0, 0, 0};
        vecs[5] = '{2, 20, 5, 0, 5, 1};
        vecs[6] = '{2, 50, 2, 0, 2, 0};

        repeat (3) tick();
        chk("reset_busy", 64'(busy_a), 64'd0);
        chk("reset_valid", 64'(valid_a), 64'd0);
        chk("reset_result", 64'(res_a), 64'd0);
        chk("reset_ovf", 64'(ovf_a), 64'd0);
        rst_n = 1'b1;
        repeat (5) tick();

        // Fixed vectors: static, periodic and saturating inputs.
        for (int i = 0; i < 7; i++) begin
            mode = vecs[i].mode;
            period = vecs[i].period;
            repeat (8) tick();
            do_start(t);
            wait_valid(v);
            chk("vec_valid_cycle", 64'(v), 64'(t + 2 + G));
            chk("vec_result_a", 64'(res_a), 64'(vecs[i].exp_a));
            chk("vec_ovf_a", 64'(ovf_a), 64'(vecs[i].ovf_a));
            chk("vec_result_s", 64'(res_s), 64'(vecs[i].exp_s));
            chk("vec_ovf_s", 64'(ovf_s), 64'(vecs[i].ovf_s));
            accept(1'b0, h);
        end

        // Random inputs, random backpressure, random continuous chaining.
        begin
            logic running;
            running = 1'b0;
            for (int i = 0; i < 10; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    mode = 3;
                    dens = $urandom_range(5, 95);
                end else begin
                    mode = 2;
                    period = $urandom_range(2, 30);
                end
                if (!running) begin
                    repeat ($urandom_range(3, 8)) tick();
                    do_start(t);
                end
                wait_valid(v);
                check_record("rand", t, v);
                repeat ($urandom_range(0, 4)) tick();
                c = (i == 9) ? 1'b0 : 1'($urandom_range(0, 1));
                accept(c, h);
                running = c;
                if (c) t = h;
            end
        end

        // Backpressure: record must hold, start ignored; then continuous handshake.
        mode = 2; period = 10;
        repeat (8) tick();
        do_start(t);
        wait_valid(v);
        check_record("bp", t, v);
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            start = (i == 5) ? 1'b1 : 1'b0;
            tick();
            if (!valid_a || !busy_a || res_a != 33'd10 || ovf_a || res_s != 33'd5 || !ovf_s) ok = 1'b0;
        end
        start = 1'b0;
        chk("bp_stable", 64'(ok), 64'd1);
        accept(1'b1, h);
        wait_valid(v);
        check_record("cont", h, v);
        accept(1'b0, h);

        // Start pulses during GATE and HOLD with ready tied high: exactly one one-cycle record.
        repeat (8) tick();
        ready = 1'b1;
        do_start(t);
        repeat (30) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(v);
        check_record("busy_start", t, v);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("hold_one_cycle_valid", 64'(valid_a), 64'd0);
        chk("hold_one_cycle_busy", 64'(busy_a), 64'd0);
        nrec = 1;
        for (int i = 0; i < G + 20; i++) begin
            tick();
            if (valid_a || busy_a) nrec++;
        end
        chk("busy_start_records", 64'(nrec), 64'd1);
        ready = 1'b0;

        // Reset at gate cycle ~50 wipes everything; a fresh gate gives a full count.
        do_start(t);
        repeat (50) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_valid", 64'(valid_a), 64'd0);
        chk("rst_result", 64'(res_a), 64'd0);
        chk("rst_ovf_s", 64'(ovf_s), 64'd0);
        chk("rst_result_s", 64'(res_s), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < G + 10; i++) begin
            tick();
            if (valid_a || busy_a) ok = 1'b0;
        end
        chk("rst_no_partial", 64'(ok), 64'd1);
        do_start(t);
        wait_valid(v);
        check_record("post_rst", t, v);
        chk("post_rst_result", 64'(res_a), 64'd10);
        accept(1'b0, h);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
